// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath: operand width, array size and
// the feeder sequencing states used by the skew feeder and the MAC array.
package tpu_pkg;

    localparam int BITS_AB_DEFAULT = 8;
    localparam int DIM_DEFAULT     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tpu_skew_feeder.sv
// Holds a DIM x DIM signed operand matrix and streams it into a systolic
// array with a diagonal skew: lane i carries row i delayed by i beats.
// A stream only starts once every row has been loaded since the last stream.
module tpu_skew_feeder
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEFAULT,
    parameter int DIM     = DIM_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [$clog2(DIM)-1:0]            row_addr,
    input  logic signed [DIM-1:0][BITS_AB-1:0] row_data,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              mac_en,
    output logic signed [DIM-1:0][BITS_AB-1:0] a_out
);

    localparam int                AW    = $clog2(DIM);
    localparam int                CNT_W = $clog2(2 * DIM);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(2 * DIM - 2);

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [DIM-1:0]                    mask_q;
    logic signed [BITS_AB-1:0]         store [DIM][DIM];
    logic signed [DIM-1:0][BITS_AB-1:0] skew;
    logic signed [DIM-1:0][BITS_AB-1:0] a_d;
    logic                              mac_en_d;
    logic                              done_d;
    logic                              wr_en;
    logic                              accept;

    // Loads are only honoured while idle; start needs the full mask as it
    // stood before this edge, so a same-cycle load cannot complete it.
    assign wr_en  = load && (state_q == IDLE);
    assign accept = start && (state_q == IDLE) && (&mask_q);
    assign busy   = (state_q != IDLE);

    // Diagonal select: lane i reads column cnt-i of row i, zero outside the matrix
    always_comb begin
        skew = '0;
        for (int i = 0; i < DIM; i++) begin
            if ((cnt_q >= CNT_W'(i)) && ((cnt_q - CNT_W'(i)) < CNT_W'(DIM)))
                skew[i] = store[i][AW'(cnt_q - CNT_W'(i))];
        end
    end

    // Next state, beat counter and next registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = '0;
        mac_en_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FEED;
                    cnt_d   = '0;
                end
            end
            FEED: begin
                a_d      = skew;
                mac_en_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_out   <= '0;
            mac_en  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_out   <= a_d;
            mac_en  <= mac_en_d;
            done    <= done_d;
        end
    end

    // Row-loaded mask: set per loaded row, cleared when a stream completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_q <= '0;
        else if (state_q == DONE)
            mask_q <= '0;
        else if (wr_en)
            mask_q[row_addr] <= 1'b1;
    end

    // Operand store; contents are only meaningful once the mask is full
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < DIM; j++)
                store[row_addr][j] <= row_data[j];
        end
    end

endmodule
